fp2int_conv: RTL

- Parametrised successor to the FPU double-to-integer converter.
- Converts a binary64 operand, or a NaN-boxed binary32 operand, to a signed or unsigned 32- or 64-bit integer.
- Honours all five RISC-V rounding modes, saturates out-of-range results to RISC-V values, and raises NV (invalid) and NX (inexact) flags.
- Sits in the FPU datapath beside the other fpu_d units; the issue logic drives it with i_ena and collects o_res/o_valid.

---
 rtl/fp2int_conv_if.sv | 24 ++
 rtl/fp2int_conv.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp2int_conv_if.sv
// Issue-side bus of the FP-to-integer converter: operand/control in, result/flags out.
interface fp2int_conv_if;
    logic        i_ena;
    logic        i_fmt;
    logic        i_signed;
    logic        i_w32;
    logic [2:0]  i_rm;
    logic [63:0] i_a;
    logic [63:0] o_res;
    logic        o_nv;
    logic        o_nx;
    logic        o_valid;
    logic        o_busy;

    modport master (
        output i_ena, i_fmt, i_signed, i_w32, i_rm, i_a,
        input  o_res, o_nv, o_nx, o_valid, o_busy
    );

    modport slave (
        input  i_ena, i_fmt, i_signed, i_w32, i_rm, i_a,
        output o_res, o_nv, o_nx, o_valid, o_busy
    );
endinterface

// File: rtl/fp2int_conv.sv
// binary64 / NaN-boxed binary32 to W/WU/L/LU converter, three register stages,
// RISC-V rounding, saturation and NV/NX flags.
module fp2int_conv #(
    parameter bit PIPELINED      = 1'b0,
    parameter bit SUPPORT_SINGLE = 1'b1
) (
    input  logic         i_clk,
    input  logic         i_nrst,
    fp2int_conv_if.slave bus
);

    typedef enum logic [1:0] {CLS_FIN, CLS_ZERO, CLS_INF, CLS_NAN} cls_e;

    typedef struct packed {
        logic [63:0] res;
        logic        nv;
        logic        nx;
    } res_t;

    function automatic logic round_inc(input logic [2:0] rm, input logic sign,
                                       input logic lsb, input logic g, input logic s);
        case (rm)
            3'd0:    return g & (lsb | s);
            3'd2:    return sign & (g | s);
            3'd3:    return ~sign & (g | s);
            3'd4:    return g;
            default: return 1'b0;
        endcase
    endfunction

    function automatic res_t saturate(input logic sign, input logic nan, input logic big,
                                      input logic sgn, input logic w32,
                                      input logic [64:0] mag_r, input logic inexact);
        res_t        o;
        logic [63:0] maxv;
        logic [63:0] minv;
        logic [64:0] neg_lim;
        o       = '0;
        maxv    = w32 ? (sgn ? 64'h0000_0000_7FFF_FFFF : 64'h0000_0000_FFFF_FFFF)
                      : (sgn ? 64'h7FFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF);
        minv    = sgn ? (w32 ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000) : 64'h0;
        neg_lim = w32 ? 65'h0_0000_0000_8000_0000 : 65'h0_8000_0000_0000_0000;
        if (nan) begin
            o.res = maxv;
            o.nv  = 1'b1;
        end else if (big) begin
            o.res = sign ? minv : maxv;
            o.nv  = 1'b1;
        end else if (sign && !sgn) begin
            // Negative to unsigned is only invalid if something survives rounding
            o.res = 64'h0;
            o.nv  = (mag_r != 65'h0);
            o.nx  = (mag_r == 65'h0) & inexact;
        end else if (sign) begin
            if (mag_r > neg_lim) begin
                o.res = minv;
                o.nv  = 1'b1;
            end else begin
                o.res = 64'h0 - mag_r[63:0];
                o.nx  = inexact;
            end
        end else if (mag_r > {1'b0, maxv}) begin
            o.res = maxv;
            o.nv  = 1'b1;
        end else begin
            o.res = mag_r[63:0];
            o.nx  = inexact;
        end
        if (w32) o.res[63:32] = {32{o.res[31]}};
        return o;
    endfunction

    logic               w_acc;
    logic               r_busy;
    logic               w_dbl_p0;
    logic               w_sign_p0;
    logic signed [12:0] w_exp_p0;
    logic [52:0]        w_sig_p0;
    cls_e               w_cls_p0;

    assign w_dbl_p0 = ~SUPPORT_SINGLE | bus.i_fmt;
    assign w_acc    = bus.i_ena & (PIPELINED | ~r_busy);

    always_comb begin
        w_sign_p0 = 1'b0;
        w_exp_p0  = '0;
        w_sig_p0  = '0;
        w_cls_p0  = CLS_FIN;
        if (w_dbl_p0) begin
            w_sign_p0 = bus.i_a[63];
            if (bus.i_a[62:52] == 11'h7FF) begin
                w_cls_p0 = (bus.i_a[51:0] != 52'h0) ? CLS_NAN : CLS_INF;
            end else if (bus.i_a[62:52] == 11'h000) begin
                w_exp_p0 = -13'sd1022;
                w_sig_p0 = {1'b0, bus.i_a[51:0]};
            end else begin
                w_exp_p0 = $signed({2'b00, bus.i_a[62:52]}) - 13'sd1023;
                w_sig_p0 = {1'b1, bus.i_a[51:0]};
            end
        end else if (!(&bus.i_a[63:32])) begin
            w_cls_p0 = CLS_NAN;
        end else begin
            w_sign_p0 = bus.i_a[31];
            if (bus.i_a[30:23] == 8'hFF) begin
                w_cls_p0 = (bus.i_a[22:0] != 23'h0) ? CLS_NAN : CLS_INF;
            end else if (bus.i_a[30:23] == 8'h00) begin
                w_exp_p0 = -13'sd126;
                w_sig_p0 = {1'b0, bus.i_a[22:0], 29'h0};
            end else begin
                w_exp_p0 = $signed({5'b00000, bus.i_a[30:23]}) - 13'sd127;
                w_sig_p0 = {1'b1, bus.i_a[22:0], 29'h0};
            end
        end
        if (w_cls_p0 == CLS_FIN && w_sig_p0 == 53'h0) w_cls_p0 = CLS_ZERO;
    end

    // ---- stage 1: unpacked operand ----
    logic               r_vld_p1;
    logic               r_sign_p1;
    logic signed [12:0] r_exp_p1;
    logic [52:0]        r_sig_p1;
    cls_e               r_cls_p1;
    logic               r_sgn_p1;
    logic               r_w32_p1;
    logic [2:0]         r_rm_p1;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_vld_p1  <= 1'b0;
            r_sign_p1 <= 1'b0;
            r_exp_p1  <= '0;
            r_sig_p1  <= '0;
            r_cls_p1  <= CLS_ZERO;
            r_sgn_p1  <= 1'b0;
            r_w32_p1  <= 1'b0;
            r_rm_p1   <= '0;
        end else begin
            r_vld_p1 <= w_acc;
            if (w_acc) begin
                r_sign_p1 <= w_sign_p0;
                r_exp_p1  <= w_exp_p0;
                r_sig_p1  <= w_sig_p0;
                r_cls_p1  <= w_cls_p0;
                r_sgn_p1  <= bus.i_signed;
                r_w32_p1  <= bus.i_w32;
                r_rm_p1   <= bus.i_rm;
            end
        end
    end

    logic [6:0]   w_sh_p1;
    logic [117:0] w_z_p1;
    logic [64:0]  w_mag_p1;
    logic         w_g_p1;
    logic         w_s_p1;
    logic         w_ovf_p1;

    assign w_sh_p1 = r_exp_p1[6:0] + 7'd1;

    // Shifting by exp+1 puts the binary point between bits 53 and 52 of w_z_p1
    always_comb begin
        w_z_p1   = '0;
        w_mag_p1 = '0;
        w_g_p1   = 1'b0;
        w_s_p1   = 1'b0;
        w_ovf_p1 = 1'b0;
        if (r_cls_p1 == CLS_FIN) begin
            if (r_exp_p1 > 13'sd63) begin
                w_ovf_p1 = 1'b1;
            end else if (r_exp_p1 < -13'sd1) begin
                w_s_p1 = (r_sig_p1 != 53'h0);
            end else begin
                w_z_p1   = {65'h0, r_sig_p1} << w_sh_p1;
                w_mag_p1 = w_z_p1[117:53];
                w_g_p1   = w_z_p1[52];
                w_s_p1   = (w_z_p1[51:0] != 52'h0);
            end
        end
    end

    // ---- stage 2: aligned magnitude with guard/sticky ----
    logic        r_vld_p2;
    logic        r_sign_p2;
    logic        r_nan_p2;
    logic        r_big_p2;
    logic [64:0] r_mag_p2;
    logic        r_g_p2;
    logic        r_s_p2;
    logic        r_sgn_p2;
    logic        r_w32_p2;
    logic [2:0]  r_rm_p2;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_vld_p2  <= 1'b0;
            r_sign_p2 <= 1'b0;
            r_nan_p2  <= 1'b0;
            r_big_p2  <= 1'b0;
            r_mag_p2  <= '0;
            r_g_p2    <= 1'b0;
            r_s_p2    <= 1'b0;
            r_sgn_p2  <= 1'b0;
            r_w32_p2  <= 1'b0;
            r_rm_p2   <= '0;
        end else begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_sign_p2 <= r_sign_p1;
                r_nan_p2  <= (r_cls_p1 == CLS_NAN);
                r_big_p2  <= (r_cls_p1 == CLS_INF) | w_ovf_p1;
                r_mag_p2  <= w_mag_p1;
                r_g_p2    <= w_g_p1;
                r_s_p2    <= w_s_p1;
                r_sgn_p2  <= r_sgn_p1;
                r_w32_p2  <= r_w32_p1;
                r_rm_p2   <= r_rm_p1;
            end
        end
    end

    logic        w_inc_p2;
    logic [64:0] w_magr_p2;
    res_t        w_out_p2;

    assign w_inc_p2  = round_inc(r_rm_p2, r_sign_p2, r_mag_p2[0], r_g_p2, r_s_p2);
    assign w_magr_p2 = r_mag_p2 + {64'h0, w_inc_p2};
    assign w_out_p2  = saturate(r_sign_p2, r_nan_p2, r_big_p2, r_sgn_p2, r_w32_p2,
                                w_magr_p2, r_g_p2 | r_s_p2);

    // ---- stage 3: rounded/saturated result, held until the next one ----
    logic [63:0] r_res;
    logic        r_nv;
    logic        r_nx;
    logic        r_valid;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_res   <= '0;
            r_nv    <= 1'b0;
            r_nx    <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_vld_p2;
            if (r_vld_p2) begin
                r_res <= w_out_p2.res;
                r_nv  <= w_out_p2.nv;
                r_nx  <= w_out_p2.nx;
            end
        end
    end

    // Single-issue: busy spans accept edge up to the edge that raises o_valid
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst)        r_busy <= 1'b0;
        else if (PIPELINED) r_busy <= 1'b0;
        else if (w_acc)     r_busy <= 1'b1;
        else if (r_vld_p2)  r_busy <= 1'b0;
    end

    assign bus.o_res   = r_res;
    assign bus.o_nv    = r_nv;
    assign bus.o_nx    = r_nx;
    assign bus.o_valid = r_valid;
    assign bus.o_busy  = r_busy;

endmodule
